multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle CPU. It decodes the latched opcode and sequences the datapath

---
 rtl/mcctrl_pkg.sv | 53 +++++
 rtl/mcctrl_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mcctrl_pkg.sv
// Shared types and constants for the multicycle CPU control FSM.
//   state_t    : 4-bit FSM state encoding (also exported on state_o for debug)
//   OP_*       : 6-bit instruction opcodes understood by the controller
//   ALUB_*     : ALUSrcB mux encodings
//   PCSRC_*    : PCSrc mux encodings
//   strobes_t  : bundle of datapath control strobes produced per state
package mcctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_M     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALUB_RT  = 2'd0;
    localparam logic [1:0] ALUB_ONE = 2'd1;
    localparam logic [1:0] ALUB_IMM = 2'd2;

    localparam logic [1:0] PCSRC_ALU = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;

    typedef struct packed {
        logic       select_ins;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_write;
        logic       mem_to_reg;
        logic       beq;
        logic [1:0] pc_src;
    } strobes_t;

endpackage

// File: rtl/mcctrl_decode.sv
// State -> datapath strobe table (Moore, except PCWrite in BRANCH follows zero).
//   state   in  : current FSM state
//   zero    in  : ALU zero flag, gates the PC load in BRANCH
//   strobes out : control strobe bundle for this state
module mcctrl_decode
    import mcctrl_pkg::*;
(
    input  state_t   state,
    input  logic     zero,
    output strobes_t strobes
);

    always_comb begin
        strobes = '0;
        case (state)
            ST_FETCH: begin
                strobes.select_ins = 1'b1;
                strobes.ir_write   = 1'b1;
                strobes.pc_write   = 1'b1;
                strobes.alu_src_b  = ALUB_ONE;
                strobes.pc_src     = PCSRC_ALU;
            end
            ST_EXEC_R: begin
                strobes.alu_src_a = 1'b1;
                strobes.alu_src_b = ALUB_RT;
            end
            ST_WB_R: begin
                strobes.reg_write = 1'b1;
                strobes.reg_dst   = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                strobes.alu_src_a = 1'b1;
                strobes.alu_src_b = ALUB_IMM;
            end
            ST_WB_I: begin
                strobes.reg_write = 1'b1;
            end
            ST_MEM_WR: begin
                strobes.mem_write = 1'b1;
            end
            ST_WB_M: begin
                strobes.reg_write  = 1'b1;
                strobes.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                strobes.alu_src_a = 1'b1;
                strobes.alu_src_b = ALUB_RT;
                strobes.beq       = 1'b1;
                strobes.pc_src    = PCSRC_BR;
                strobes.pc_write  = zero;
            end
            ST_JUMP: begin
                strobes.pc_src   = PCSRC_JMP;
                strobes.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU: decodes the opcode, sequences datapath
// strobes, inserts memory wait states, flags illegal opcodes and counts
// retired instructions.
// Optional feature macro: MCCTRL_MEMRDY_EN adds a mem_ready handshake that
// replaces the fixed MEM_WAIT timing in MEM_RD / MEM_WR.
//   clk, rst (sync, active-high)
//   opcode (OPW), zero, [mem_ready]        : inputs from datapath / memory
//   SelectIns .. PCSrc                     : datapath control strobes
//   illegal_op                             : pulse in DECODE on unknown opcode
//   retired (CNTW)                         : completed-instruction counter
//   state_o (4)                            : current state, debug
module multicycle_ctrl
    import mcctrl_pkg::*;
#(
    parameter int unsigned OPW      = 6,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
`ifdef MCCTRL_MEMRDY_EN
    input  logic            mem_ready,
`endif
    output logic            SelectIns,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            BEQ,
    output logic [1:0]      PCSrc,
    output logic            illegal_op,
    output logic [CNTW-1:0] retired,
    output logic [3:0]      state_o
);

    // Compare opcodes at the wider of OPW and the package constant width.
    localparam int unsigned CMPW = (OPW > 6) ? OPW : 6;

    state_t         state;
    logic           is_lw;
    logic           mem_done_c;
    strobes_t       strb;
    logic [CMPW-1:0] op_ext;
    logic           op_r, op_j, op_beq, op_addi, op_lw, op_sw, op_known;

    assign op_ext   = CMPW'(opcode);
    assign op_r     = (op_ext == CMPW'(OP_R));
    assign op_j     = (op_ext == CMPW'(OP_J));
    assign op_beq   = (op_ext == CMPW'(OP_BEQ));
    assign op_addi  = (op_ext == CMPW'(OP_ADDI));
    assign op_lw    = (op_ext == CMPW'(OP_LW));
    assign op_sw    = (op_ext == CMPW'(OP_SW));
    assign op_known = op_r | op_j | op_beq | op_addi | op_lw | op_sw;

    // Memory-state exit condition: handshake or fixed wait count.
`ifdef MCCTRL_MEMRDY_EN
    assign mem_done_c = mem_ready;
`else
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == ST_MEM_RD || state == ST_MEM_WR) && !mem_done_c) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign mem_done_c = (wait_cnt == 4'(MEM_WAIT));
`endif

    // State sequencing and retire counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            is_lw   <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    is_lw <= op_lw;
                    if (op_r)                state <= ST_EXEC_R;
                    else if (op_addi)        state <= ST_EXEC_I;
                    else if (op_lw || op_sw) state <= ST_MEM_ADDR;
                    else if (op_beq)         state <= ST_BRANCH;
                    else if (op_j)           state <= ST_JUMP;
                    else                     state <= ST_FETCH;
                end
                ST_EXEC_R:   state <= ST_WB_R;
                ST_EXEC_I:   state <= ST_WB_I;
                ST_MEM_ADDR: state <= is_lw ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (mem_done_c) state <= ST_WB_M;
                end
                ST_MEM_WR: begin
                    if (mem_done_c) begin
                        state   <= ST_FETCH;
                        retired <= retired + CNTW'(1);
                    end
                end
                ST_WB_R, ST_WB_I, ST_WB_M, ST_BRANCH, ST_JUMP: begin
                    state   <= ST_FETCH;
                    retired <= retired + CNTW'(1);
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    mcctrl_decode u_decode (
        .state   (state),
        .zero    (zero),
        .strobes (strb)
    );

    // All strobes are held low while reset is asserted, whatever the state.
    assign SelectIns  = !rst && strb.select_ins;
    assign IRWrite    = !rst && strb.ir_write;
    assign PCWrite    = !rst && strb.pc_write;
    assign RegWrite   = !rst && strb.reg_write;
    assign RegDst     = !rst && strb.reg_dst;
    assign ALUSrcA    = !rst && strb.alu_src_a;
    assign ALUSrcB    = rst ? 2'b00 : strb.alu_src_b;
    assign MemWrite   = !rst && strb.mem_write;
    assign MemtoReg   = !rst && strb.mem_to_reg;
    assign BEQ        = !rst && strb.beq;
    assign PCSrc      = rst ? 2'b00 : strb.pc_src;
    assign illegal_op = !rst && (state == ST_DECODE) && !op_known;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_WAIT=2, CNTW=4): directed
// scenarios plus a random instruction stream against a trace-level model.
module tb_multicycle_ctrl;
    import mcctrl_pkg::*;

`ifdef MCCTRL_MEMRDY_EN
    localparam int unsigned WAITS = 0;
`else
    localparam int unsigned WAITS = 2;
`endif

    logic       clk, rst, zero;
    logic [5:0] opcode;
    logic       SelectIns, IRWrite, PCWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       MemWrite, MemtoReg, BEQ, illegal_op;
    logic [3:0] retired, state_o;
`ifdef MCCTRL_MEMRDY_EN
    logic       mem_ready;
`endif

    multicycle_ctrl #(.OPW(6), .MEM_WAIT(2), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef MCCTRL_MEMRDY_EN
        .mem_ready(mem_ready),
`endif
        .SelectIns(SelectIns), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .BEQ(BEQ), .PCSrc(PCSrc), .illegal_op(illegal_op),
        .retired(retired), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed strobe vector, one bit-field per output.
    logic [13:0] obs;
    assign obs = {SelectIns, IRWrite, PCWrite, RegWrite, RegDst, ALUSrcA,
                  ALUSrcB, MemWrite, MemtoReg, BEQ, PCSrc, illegal_op};

    localparam logic [13:0] M_SEL   = 14'h2000;
    localparam logic [13:0] M_IRW   = 14'h1000;
    localparam logic [13:0] M_PCW   = 14'h0800;
    localparam logic [13:0] M_RW    = 14'h0400;
    localparam logic [13:0] M_RD    = 14'h0200;
    localparam logic [13:0] M_ASA   = 14'h0100;
    localparam logic [13:0] ASB_IMM = 14'h0080;
    localparam logic [13:0] ASB_ONE = 14'h0040;
    localparam logic [13:0] M_MW    = 14'h0020;
    localparam logic [13:0] M_M2R   = 14'h0010;
    localparam logic [13:0] M_BEQ   = 14'h0008;
    localparam logic [13:0] PCS_J   = 14'h0004;
    localparam logic [13:0] PCS_BR  = 14'h0002;
    localparam logic [13:0] M_ILL   = 14'h0001;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] sv;
    } exp_t;

    exp_t       trace[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] model_ret = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic is_known(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

    function automatic void push(input state_t st, input logic [13:0] sv);
        exp_t e;
        e.st = st;
        e.sv = sv;
        trace.push_back(e);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, straight from the rules.
    function automatic void build(input logic [5:0] op, input logic z);
        trace.delete();
        push(ST_FETCH, M_SEL | M_IRW | M_PCW | ASB_ONE);
        push(ST_DECODE, is_known(op) ? 14'h0 : M_ILL);
        case (op)
            OP_R: begin
                push(ST_EXEC_R, M_ASA);
                push(ST_WB_R, M_RW | M_RD);
            end
            OP_ADDI: begin
                push(ST_EXEC_I, M_ASA | ASB_IMM);
                push(ST_WB_I, M_RW);
            end
            OP_LW: begin
                push(ST_MEM_ADDR, M_ASA | ASB_IMM);
                for (int k = 0; k < int'(WAITS) + 1; k++) push(ST_MEM_RD, 14'h0);
                push(ST_WB_M, M_RW | M_M2R);
            end
            OP_SW: begin
                push(ST_MEM_ADDR, M_ASA | ASB_IMM);
                for (int k = 0; k < int'(WAITS) + 1; k++) push(ST_MEM_WR, M_MW);
            end
            OP_BEQ: push(ST_BRANCH, M_ASA | M_BEQ | PCS_BR | (z ? M_PCW : 14'h0));
            OP_J:   push(ST_JUMP, M_PCW | PCS_J);
            default: ;
        endcase
    endfunction

    // Step one instruction from its FETCH cycle; opcode is scrambled after DECODE.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
        opcode = op;
        zero   = z;
        build(op, z);
        #1;
        foreach (trace[i]) begin
            check_eq({tag, "_state"}, 32'(state_o), 32'(trace[i].st));
            check_eq({tag, "_strobes"}, 32'(obs), 32'(trace[i].sv));
            @(posedge clk);
            #1;
            if (trace[i].st == 4'(ST_DECODE)) opcode = 6'($urandom);
            #1;
        end
        if (is_known(op)) model_ret = model_ret + 4'd1;
        check_eq({tag, "_retired"}, 32'(retired), 32'(model_ret));
    endtask

    // LW aborted by reset in its first MEM_RD cycle.
    task automatic abort_lw();
        opcode = OP_LW;
        zero   = 1'b0;
        build(OP_LW, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_pre_state", 32'(state_o), 32'(trace[i].st));
            @(posedge clk);
            #1;
        end
        check_eq("abort_in_memrd", 32'(state_o), 32'(ST_MEM_RD));
        rst = 1'b1;
        #1;
        check_eq("abort_rst_strobes", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        model_ret = '0;
        check_eq("abort_rst_state", 32'(state_o), 32'(ST_FETCH));
        check_eq("abort_rst_strobes2", 32'(obs), 32'h0);
        check_eq("abort_retired", 32'(retired), 32'(model_ret));
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [5:0] legal[6];
        logic [5:0] op;
        legal = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};

        rst    = 1'b1;
        opcode = '0;
        zero   = 1'b0;
`ifdef MCCTRL_MEMRDY_EN
        mem_ready = 1'b1;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst_strobes", 32'(obs), 32'h0);
            check_eq("rst_retired", 32'(retired), 32'h0);
        end
        rst = 1'b0;
        #1;

        run_instr("addi", OP_ADDI, 1'b0);
        run_instr("sw", OP_SW, 1'b0);
        run_instr("lw", OP_LW, 1'b1);
        run_instr("beq_t", OP_BEQ, 1'b1);
        run_instr("beq_nt", OP_BEQ, 1'b0);
        run_instr("illegal", 6'h3F, 1'b0);
        run_instr("r", OP_R, 1'b1);
        for (int i = 0; i < 16; i++) run_instr("jwrap", OP_J, 1'($urandom));

        abort_lw();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) < 6) op = legal[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            run_instr("rand", op, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
